// File: rtl/ex_result_buffer_if.sv
// Execute-stage result buffer bus: producer (ALU) side, consumer (MEM/WB) side and
// the forwarding lookup toward the ALU operand busses.
interface ex_result_buffer_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGBITS = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_result;
    logic               in_carry;
    logic               in_zero;
    logic               in_overflow;
    logic               in_negative;
    logic [REGBITS-1:0] in_rd;
    logic               in_wen;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_result;
    logic [3:0]         out_flags;
    logic [REGBITS-1:0] out_rd;
    logic               out_wen;

    logic [REGBITS-1:0] fwd_rs;
    logic [REGBITS-1:0] fwd_rt;
    logic               fwd_a_hit;
    logic [WIDTH-1:0]   fwd_a_data;
    logic               fwd_b_hit;
    logic [WIDTH-1:0]   fwd_b_data;

    logic [1:0]         count;

    // Driver of inputs / consumer of outputs (pipeline and test environment).
    modport master (
        output in_valid, in_result, in_carry, in_zero, in_overflow, in_negative, in_rd, in_wen,
        output out_ready, fwd_rs, fwd_rt,
        input  in_ready, out_valid, out_result, out_flags, out_rd, out_wen,
        input  fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data, count
    );

    // The buffer itself.
    modport slave (
        input  in_valid, in_result, in_carry, in_zero, in_overflow, in_negative, in_rd, in_wen,
        input  out_ready, fwd_rs, fwd_rt,
        output in_ready, out_valid, out_result, out_flags, out_rd, out_wen,
        output fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data, count
    );
endinterface

// File: rtl/ex_result_buffer.sv
// Two-entry FIFO between execute and MEM/WB. Holds ALU results and flags so a downstream
// stall never drops one, and forwards buffered results back to the ALU operands.
module ex_result_buffer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGBITS = 5
) (
    input logic               clk,
    input logic               reset,
    input logic               flush,
    ex_result_buffer_if.slave bus
);
    logic [WIDTH-1:0]   result_q [2];
    logic [WIDTH-1:0]   result_d [2];
    logic [3:0]         flags_q  [2];
    logic [3:0]         flags_d  [2];
    logic [REGBITS-1:0] rd_q     [2];
    logic [REGBITS-1:0] rd_d     [2];
    logic [1:0]         wen_q;
    logic [1:0]         wen_d;
    logic               rd_ptr_q;
    logic               rd_ptr_d;
    logic               wr_ptr_q;
    logic               wr_ptr_d;
    logic [1:0]         count_q;
    logic [1:0]         count_d;

    logic               push;
    logic               pop;

    // Forwarding candidates: youngest sits just behind the write pointer; the older one is
    // the head and is only distinct from the youngest when the buffer is full.
    logic               young_idx;
    logic               old_idx;
    logic               young_ok;
    logic               old_ok;

    // Handshake and head-entry outputs; all come straight from registered state.
    always_comb begin
        bus.in_ready   = (count_q != 2'd2);
        bus.out_valid  = (count_q != 2'd0);
        bus.out_result = result_q[rd_ptr_q];
        bus.out_flags  = flags_q[rd_ptr_q];
        bus.out_rd     = rd_q[rd_ptr_q];
        bus.out_wen    = wen_q[rd_ptr_q];
        bus.count      = count_q;
    end

    // Next-state: flush squashes occupancy but leaves storage; push in a flush cycle is dropped.
    always_comb begin
        push     = bus.in_valid & (count_q != 2'd2);
        pop      = bus.out_ready & (count_q != 2'd0);
        result_d = result_q;
        flags_d  = flags_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                result_d[wr_ptr_q] = bus.in_result;
                flags_d[wr_ptr_q]  = {bus.in_negative, bus.in_overflow, bus.in_zero,
                                      bus.in_carry};
                rd_d[wr_ptr_q]     = bus.in_rd;
                wen_d[wr_ptr_q]    = bus.in_wen;
                wr_ptr_d           = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset also clears storage so the head reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                result_q[i] <= '0;
                flags_q[i]  <= '0;
                rd_q[i]     <= '0;
            end
            wen_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            rd_q     <= rd_d;
            wen_q    <= wen_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Forwarding lookup; youngest matching entry wins, register 0 never hits.
    always_comb begin
        young_idx      = ~wr_ptr_q;
        old_idx        = rd_ptr_q;
        young_ok       = (count_q != 2'd0) && wen_q[young_idx] && (rd_q[young_idx] != '0);
        old_ok         = (count_q == 2'd2) && wen_q[old_idx] && (rd_q[old_idx] != '0);
        bus.fwd_a_hit  = 1'b0;
        bus.fwd_a_data = '0;
        bus.fwd_b_hit  = 1'b0;
        bus.fwd_b_data = '0;
        if (young_ok && (rd_q[young_idx] == bus.fwd_rs)) begin
            bus.fwd_a_hit  = 1'b1;
            bus.fwd_a_data = result_q[young_idx];
        end else if (old_ok && (rd_q[old_idx] == bus.fwd_rs)) begin
            bus.fwd_a_hit  = 1'b1;
            bus.fwd_a_data = result_q[old_idx];
        end
        if (young_ok && (rd_q[young_idx] == bus.fwd_rt)) begin
            bus.fwd_b_hit  = 1'b1;
            bus.fwd_b_data = result_q[young_idx];
        end else if (old_ok && (rd_q[old_idx] == bus.fwd_rt)) begin
            bus.fwd_b_hit  = 1'b1;
            bus.fwd_b_data = result_q[old_idx];
        end
    end
endmodule

// File: tb/tb_ex_result_buffer.sv
// Directed bench for ex_result_buffer: a queue of expected entries is pushed on each
// accepted input and compared against the head output; forwarding is modelled from the queue.
module tb_ex_result_buffer;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned REGBITS = 5;

    typedef struct packed {
        logic [WIDTH-1:0]   result;
        logic [3:0]         flags;
        logic [REGBITS-1:0] rd;
        logic               wen;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    ex_result_buffer_if #(.WIDTH(WIDTH), .REGBITS(REGBITS)) bus ();

    ex_result_buffer #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    entry_t sb[$];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest valid entry with wen=1 and matching non-zero rd.
    function automatic void fwd_model(input logic [REGBITS-1:0] r, output logic hit,
                                      output logic [WIDTH-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (r != '0) begin
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].wen && sb[i].rd == r) begin
                    hit  = 1'b1;
                    data = sb[i].result;
                end
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [WIDTH-1:0] res, input logic c,
                         input logic z, input logic o, input logic n,
                         input logic [REGBITS-1:0] rd, input logic wen);
        bus.in_valid    = v;
        bus.in_result   = res;
        bus.in_carry    = c;
        bus.in_zero     = z;
        bus.in_overflow = o;
        bus.in_negative = n;
        bus.in_rd       = rd;
        bus.in_wen      = wen;
    endtask

    // Check current outputs against the model, update the model, advance one clock.
    task automatic cycle();
        logic             h;
        logic [WIDTH-1:0] d;
        logic             do_push;
        logic             do_pop;
        entry_t           e;
        check("count", 64'(bus.count), 64'(sb.size()));
        check("in_ready", 64'(bus.in_ready), 64'(sb.size() != 2));
        check("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_result", 64'(bus.out_result), 64'(sb[0].result));
            check("out_flags", 64'(bus.out_flags), 64'(sb[0].flags));
            check("out_rd", 64'(bus.out_rd), 64'(sb[0].rd));
            check("out_wen", 64'(bus.out_wen), 64'(sb[0].wen));
        end
        fwd_model(bus.fwd_rs, h, d);
        check("fwd_a_hit", 64'(bus.fwd_a_hit), 64'(h));
        check("fwd_a_data", 64'(bus.fwd_a_data), 64'(d));
        fwd_model(bus.fwd_rt, h, d);
        check("fwd_b_hit", 64'(bus.fwd_b_hit), 64'(h));
        check("fwd_b_data", 64'(bus.fwd_b_data), 64'(d));
        do_push = bus.in_valid && (sb.size() < 2);
        do_pop  = bus.out_ready && (sb.size() != 0);
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                e.result = bus.in_result;
                e.flags  = {bus.in_negative, bus.in_overflow, bus.in_zero, bus.in_carry};
                e.rd     = bus.in_rd;
                e.wen    = bus.in_wen;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        bus.fwd_rs    = 5'd3;
        bus.fwd_rt    = 5'd0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_out_flags", 64'(bus.out_flags), 64'd0);
        check("rst_a_hit", 64'(bus.fwd_a_hit), 64'd0);

        // 1: single push, 1-cycle latency
        drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("t1_out_valid", 64'(bus.out_valid), 64'd1);
        check("t1_out_result", 64'(bus.out_result), 64'h5);
        check("t1_count", 64'(bus.count), 64'd1);
        check("t1_fwd_a", 64'(bus.fwd_a_data), 64'h5);
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;

        // 2: A, B, C back-to-back; C must be held while full
        drive(1'b1, 32'hA, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
        cycle();
        drive(1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1);
        cycle();
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
        check("t2_in_ready_full", 64'(bus.in_ready), 64'd0);
        check("t2_count_full", 64'(bus.count), 64'd2);
        cycle();
        cycle();
        bus.out_ready = 1'b1;
        check("t2_head_a", 64'(bus.out_result), 64'hA);
        cycle();
        check("t2_head_b", 64'(bus.out_result), 64'hB);
        cycle();
        // 3: C entered while B left; count stays 1 on push+pop
        drive(1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
        check("t2_head_c", 64'(bus.out_result), 64'hC);
        cycle();
        check("t3_count", 64'(bus.count), 64'd1);
        check("t3_head_d", 64'(bus.out_result), 64'hD);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle();
        cycle();
        bus.out_ready = 1'b0;

        // 4: forwarding, youngest wins; register 0 never hits
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
        cycle();
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        bus.fwd_rs = 5'd7;
        bus.fwd_rt = 5'd7;
        #1;
        check("t4_a_hit", 64'(bus.fwd_a_hit), 64'd1);
        check("t4_a_data", 64'(bus.fwd_a_data), 64'h22);
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        cycle();
        drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
        bus.fwd_rs = 5'd9;
        bus.fwd_rt = 5'd0;
        #1;
        check("t4_a_young_7", 64'(bus.fwd_a_hit), 64'd0);
        cycle();
        check("t4_b_reg0", 64'(bus.fwd_b_hit), 64'd0);
        check("t4_a_wen0", 64'(bus.fwd_a_hit), 64'd0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        // 5: flag packing {n, o, z, c}
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 1'b1);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("t5_flags", 64'(bus.out_flags), 64'b0101);
        cycle();

        // 6a: reset while full
        drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        bus.fwd_rs = 5'd8;
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("t6_full", 64'(bus.count), 64'd2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t6_rst_count", 64'(bus.count), 64'd0);
        check("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("t6_rst_a_hit", 64'(bus.fwd_a_hit), 64'd0);
        check("t6_rst_out_result", 64'(bus.out_result), 64'd0);
        cycle();

        // 6b: flush while full, with a push in the flush cycle
        drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        cycle();
        cycle();
        flush = 1'b1;
        drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("t6_fl_count", 64'(bus.count), 64'd0);
        check("t6_fl_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_fl_in_ready", 64'(bus.in_ready), 64'd1);
        check("t6_fl_a_hit", 64'(bus.fwd_a_hit), 64'd0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
